// File: rtl/sr_drv_pkg.sv
// Shared types and command encodings for the SR latch driver.
// The phase order is fixed: IDLE -> SETUP -> ENABLE -> HOLD -> IDLE.
package sr_drv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ENABLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_RST = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;

endpackage

// File: rtl/sr_phase_timer.sv
// Loadable down-counter shared by all driver phases; zero flag is a decode of the count.
// Load has priority over decrement, and the count never wraps below zero.
module sr_phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Sequences set/reset commands into setup, enable pulse and hold phases for a gated SR latch.
// S/R are only ever changed with en low and are never driven high together.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 1,
    parameter int CNT_W     = 4,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    output logic             S,
    output logic             R,
    output logic             en,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt
);

    // Timer loads hold "cycles minus one" so a phase ends on the zero cycle.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    state_t           state, state_n;
    logic             s_n, r_n, en_n, busy_n, done_n;
    logic [ERR_W-1:0] err_n;
    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_val;
    logic             accept;

    assign cmd_ready = (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    sr_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            S       <= 1'b0;
            R       <= 1'b0;
            en      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_n;
            S       <= s_n;
            R       <= r_n;
            en      <= en_n;
            busy    <= busy_n;
            done    <= done_n;
            err_cnt <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        s_n      = S;
        r_n      = R;
        en_n     = en;
        busy_n   = busy;
        done_n   = 1'b0;
        err_n    = err_cnt;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_SET, OP_RST: begin
                            state_n  = SETUP;
                            s_n      = (cmd_op == OP_SET);
                            r_n      = (cmd_op == OP_RST);
                            busy_n   = 1'b1;
                            tmr_load = 1'b1;
                            tmr_val  = SETUP_LD;
                        end
                        OP_ILL: begin
                            if (err_cnt != '1) begin
                                err_n = err_cnt + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_n  = ENABLE;
                    en_n     = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = EN_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ENABLE: begin
                if (tmr_zero) begin
                    state_n  = HOLD;
                    en_n     = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    state_n = IDLE;
                    s_n     = 1'b0;
                    r_n     = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench: per-cycle expected S/R/en/busy/done/ready values are queued per command
// and popped each cycle; a monitor checks the latch-safety invariants on both instances.
module tb_sr_latch_driver;

    typedef struct packed {
        logic s;
        logic r;
        logic en;
        logic busy;
        logic done;
        logic ready;
    } obs_t;

    logic       clk;
    logic       rst, rst2;
    logic       cmd_valid, cmd_valid2;
    logic [1:0] cmd_op, cmd_op2;
    logic       cmd_ready, cmd_ready2;
    logic       s1, r1, en1, busy1, done1;
    logic       s2, r2, en2, busy2, done2;
    logic [7:0] err_cnt, err_cnt2;

    int checks = 0;
    int errors = 0;
    obs_t exp_q[$];

    sr_latch_driver dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .S(s1), .R(r1), .en(en1), .busy(busy1), .done(done1), .err_cnt(err_cnt)
    );

    sr_latch_driver #(.SETUP_CYC(3), .EN_CYC(1), .HOLD_CYC(2)) dut2 (
        .clk(clk), .rst(rst2), .cmd_valid(cmd_valid2), .cmd_op(cmd_op2), .cmd_ready(cmd_ready2),
        .S(s2), .R(r2), .en(en2), .busy(busy2), .done(done2), .err_cnt(err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t get_obs(input int sel);
        obs_t o;
        if (sel == 0) o = '{s1, r1, en1, busy1, done1, cmd_ready};
        else          o = '{s2, r2, en2, busy2, done2, cmd_ready2};
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected trace from the accept edge onward: busy phases, then the done cycle.
    task automatic push_op(input logic [1:0] op, input int su, input int ec, input int hc);
        obs_t e;
        for (int i = 0; i < su + ec + hc; i++) begin
            e = '{(op == 2'b01), (op == 2'b10), (i >= su && i < su + ec), 1'b1, 1'b0, 1'b0};
            exp_q.push_back(e);
        end
        e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_q.push_back(e);
    endtask

    task automatic check_one(input string name, input int sel);
        obs_t o, e;
        o = get_obs(sel);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, observed srebdy=%b", name, o);
        end else begin
            e = exp_q.pop_front();
            if (o !== e) begin
                errors++;
                $display("FAIL %s @%0t: srebdy=%b expected %b", name, $time, o, e);
            end
        end
    endtask

    task automatic run_op(input string name, input int sel, input logic [1:0] op,
                          input int su, input int ec, input int hc);
        if (sel == 0) begin cmd_valid = 1'b1; cmd_op = op; end
        else          begin cmd_valid2 = 1'b1; cmd_op2 = op; end
        step();
        cmd_valid = 1'b0; cmd_valid2 = 1'b0;
        push_op(op, su, ec, hc);
        for (int i = 0; i <= su + ec + hc; i++) begin
            check_one(name, sel);
            if (i < su + ec + hc) step();
        end
    endtask

    task automatic check_idle(input string name, input int sel, input logic [7:0] exp_err);
        obs_t o;
        logic [7:0] ec;
        o  = get_obs(sel);
        ec = (sel == 0) ? err_cnt : err_cnt2;
        checks++;
        if (o !== 6'b000001 || ec !== exp_err) begin
            errors++;
            $display("FAIL %s: srebdy=%b err_cnt=%0d expected 000001 err_cnt=%0d", name, o, ec, exp_err);
        end
    endtask

    // Invariant monitor; S/R steps are exempt on edges where reset was applied.
    logic [1:0] prev_s, prev_r, prev_en, prev_rst;
    initial begin prev_s = '0; prev_r = '0; prev_en = '0; prev_rst = '1; end
    always @(negedge clk) begin
        obs_t o;
        for (int d = 0; d < 2; d++) begin
            o = get_obs(d);
            checks++;
            if ((o.s && o.r) || (o.en && !(o.s ^ o.r)) || (o.busy === o.ready) ||
                (!prev_rst[d] && ((o.s != prev_s[d]) || (o.r != prev_r[d])) && (o.en || prev_en[d]))) begin
                errors++;
                $display("FAIL invariant dut%0d @%0t: srebdy=%b", d, $time, o);
            end
            prev_s[d]   = o.s;
            prev_r[d]   = o.r;
            prev_en[d]  = o.en;
            prev_rst[d] = (d == 0) ? rst : rst2;
        end
    end

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1;
        cmd_valid = 1'b0; cmd_valid2 = 1'b0; cmd_op = 2'b00; cmd_op2 = 2'b00;
        step(); step();
        rst = 1'b0; rst2 = 1'b0;
        check_idle("reset_dut", 0, 8'd0);
        check_idle("reset_dut2", 1, 8'd0);
    endtask

    task automatic test_set();
        run_op("set", 0, 2'b01, 1, 2, 1);
        step();
        check_idle("set_after", 0, 8'd0);
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1; cmd_op = 2'b10;
        step();
        cmd_op = 2'b01;
        push_op(2'b10, 1, 2, 1);
        push_op(2'b01, 1, 2, 1);
        for (int i = 0; i < 5; i++) begin
            check_one("b2b_rst", 0);
            step();
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_one("b2b_set", 0);
            if (i < 4) step();
        end
        step();
        check_idle("b2b_after", 0, 8'd0);
    endtask

    task automatic test_illegal();
        cmd_valid = 1'b1; cmd_op = 2'b11;
        for (int i = 0; i < 3; i++) step();
        cmd_op = 2'b00;
        step();
        cmd_valid = 1'b0;
        check_idle("illegal_x3", 0, 8'd3);
        cmd_valid = 1'b1; cmd_op = 2'b11;
        for (int i = 0; i < 252; i++) step();
        cmd_valid = 1'b0;
        check_idle("illegal_255", 0, 8'd255);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check_idle("illegal_sat", 0, 8'd255);
    endtask

    task automatic test_reset_mid_op();
        cmd_valid = 1'b1; cmd_op = 2'b01;
        step();
        cmd_valid = 1'b0;
        step();
        checks++;
        if (en1 !== 1'b1) begin
            errors++;
            $display("FAIL mid_enable: en=%b expected 1", en1);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle("mid_reset", 0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("mid_no_done", 0, 8'd0);
        end
        run_op("set_after_reset", 0, 2'b01, 1, 2, 1);
    endtask

    task automatic test_params();
        run_op("params_set", 1, 2'b01, 3, 1, 2);
        step();
        run_op("params_rst", 1, 2'b10, 3, 1, 2);
    endtask

    initial begin
        test_reset();
        test_set();
        test_back_to_back();
        test_illegal();
        test_reset_mid_op();
        test_params();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
